// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one outstanding RV32I access to the unified memory/MMIO bus,
// with byte-lane masking, load extension, misalignment trapping and an ack timeout.
module lsu_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int NUM_LANES = 4;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [2:0]        f3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  state_t            state, state_d;
  logic [TO_W-1:0]   cnt, cnt_d;
  req_t              req_q, req_d, req_in;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              illegal;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;
  logic              st_act;

  assign req_in = '{we: req_we, f3: req_funct3, addr: req_addr, wdata: req_wdata};

  always_comb begin
    illegal = 1'b0;
    if (!req_we && (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7))
      illegal = 1'b1;
    if (req_we && req_funct3 > 3'd2)
      illegal = 1'b1;
    if (req_funct3[1:0] == 2'd1 && req_addr[0])
      illegal = 1'b1;
    if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00)
      illegal = 1'b1;
  end

  // funct3[2] selects zero extension (lbu/lhu)
  assign ld_byte = mem_rdata[{req_q.addr[1:0], 3'b000} +: 8];
  assign ld_half = mem_rdata[{req_q.addr[1], 4'b0000} +: 16];

  always_comb begin
    case (req_q.f3[1:0])
      2'd0:    ld_ext = {{24{~req_q.f3[2] & ld_byte[7]}}, ld_byte};
      2'd1:    ld_ext = {{16{~req_q.f3[2] & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    req_d   = req_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          req_d   = req_in;
          err_d   = illegal;
          rdata_d = '0;
          state_d = illegal ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          err_d   = 1'b0;
          rdata_d = req_q.we ? 32'h0 : ld_ext;
          state_d = RESP;
        end else begin
          cnt_d = cnt + TO_W'(1);
          if (cnt == TO_LAST) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign mem_req    = (state == ACCESS);
  assign mem_we     = mem_req & req_q.we;
  assign mem_addr   = mem_req ? {req_q.addr[ADDR_W-1:2], 2'b00} : '0;
  assign st_act     = mem_req & req_q.we;

  // Each byte lane picks its enable and replicated source byte from the access size
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    always_comb begin
      mem_wmask[i]        = 1'b0;
      mem_wdata[8*i +: 8] = 8'h0;
      if (st_act) begin
        case (req_q.f3[1:0])
          2'd0: begin
            mem_wmask[i]        = (req_q.addr[1:0] == 2'(i));
            mem_wdata[8*i +: 8] = req_q.wdata[7:0];
          end
          2'd1: begin
            mem_wmask[i]        = (req_q.addr[1] == 1'(i / 2));
            mem_wdata[8*i +: 8] = req_q.wdata[8*(i%2) +: 8];
          end
          default: begin
            mem_wmask[i]        = 1'b1;
            mem_wdata[8*i +: 8] = req_q.wdata[8*i +: 8];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench: stimulus pushes expected responses, monitors pop and compare.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, rv2, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic        mem_ack, ack2;

  logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        req_ready2, resp_valid2, resp_err2, mem_req2, mem_we2;
  logic [31:0] resp_rdata2, mem_addr2, mem_wdata2;
  logic [3:0]  mem_wmask2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(16), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(4), .TO_W(3)) dut_to (
    .clk(clk), .reset(reset), .req_valid(rv2), .req_ready(req_ready2),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .resp_err(resp_err2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wmask(mem_wmask2),
    .mem_wdata(mem_wdata2), .mem_ack(ack2), .mem_rdata(mem_rdata));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (resp_valid) begin
      if (q1.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("resp_cycle", 32'(cyc), 32'(e.at));
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (resp_valid2) begin
      if (q2.size() == 0) chk("unexpected_resp2", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        chk("resp2_cycle", 32'(cyc), 32'(e.at));
        chk("resp2_rdata", resp_rdata2, e.rdata);
        chk("resp2_err", {31'd0, resp_err2}, {31'd0, e.err});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int d,
                       input logic [31:0] mrd, input logic [31:0] exp_rd, input logic ill,
                       input logic [3:0] emask, input logic [31:0] ewd);
    exp_t e;
    wait_ready();
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    e.rdata = exp_rd;
    e.err   = ill;
    e.at    = ill ? cyc + 1 : cyc + 2 + d;
    q1.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (ill) begin
      chk({nm, "_no_memreq"}, {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      chk({nm, "_no_memreq2"}, {31'd0, mem_req}, 32'd0);
    end else begin
      chk({nm, "_memreq"}, {31'd0, mem_req}, 32'd1);
      chk({nm, "_ready_low"}, {31'd0, req_ready}, 32'd0);
      chk({nm, "_we"}, {31'd0, mem_we}, {31'd0, we});
      chk({nm, "_addr"}, mem_addr, addr & ~32'h3);
      chk({nm, "_wmask"}, {28'd0, mem_wmask}, {28'd0, emask});
      if (we) chk({nm, "_wdata"}, mem_wdata, ewd);
      repeat (d) @(negedge clk);
      if (d > 0) chk({nm, "_memreq_held"}, {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1;
      mem_rdata = mrd;
      @(posedge clk);
      #1 mem_ack = 1'b0;
    end
  endtask

  initial begin
    int mcnt;
    exp_t e;
    reset = 1'b0; req_valid = 1'b0; rv2 = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; ack2 = 1'b0; mem_rdata = 32'h0;
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_outs", {28'd0, resp_valid, resp_err, mem_req, mem_we}, 32'd0);
    chk("rst_wmask", {28'd0, mem_wmask}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    issue("lb",     0, 3'd0, 32'h103, 32'h0, 0, 32'h80FF7F01, 32'hFFFFFF80, 0, 4'b0000, 32'h0);
    issue("lbu",    0, 3'd4, 32'h103, 32'h0, 0, 32'h80FF7F01, 32'h00000080, 0, 4'b0000, 32'h0);
    issue("lh",     0, 3'd1, 32'h102, 32'h0, 0, 32'h80FF7F01, 32'hFFFF80FF, 0, 4'b0000, 32'h0);
    issue("lw",     0, 3'd2, 32'h100, 32'h0, 0, 32'h80FF7F01, 32'h80FF7F01, 0, 4'b0000, 32'h0);
    issue("lhu",    0, 3'd5, 32'h100, 32'h0, 0, 32'h80FF7F01, 32'h00007F01, 0, 4'b0000, 32'h0);
    issue("lb_pos", 0, 3'd0, 32'h101, 32'h0, 0, 32'h80FF7F01, 32'h0000007F, 0, 4'b0000, 32'h0);
    issue("sb", 1, 3'd0, 32'h201, 32'h123456AB, 0, 32'h55555555, 32'h0, 0, 4'b0010, 32'hABABABAB);
    issue("sh", 1, 3'd1, 32'h202, 32'h00001234, 0, 32'h55555555, 32'h0, 0, 4'b1100, 32'h12341234);
    issue("sw", 1, 3'd2, 32'h204, 32'hDEADBEEF, 0, 32'h55555555, 32'h0, 0, 4'b1111, 32'hDEADBEEF);
    issue("lw_mis",  0, 3'd2, 32'h102, 32'h0, 0, 32'h0, 32'h0, 1, 4'b0000, 32'h0);
    issue("lh_mis",  0, 3'd1, 32'h101, 32'h0, 0, 32'h0, 32'h0, 1, 4'b0000, 32'h0);
    issue("ld_f3_3", 0, 3'd3, 32'h100, 32'h0, 0, 32'h0, 32'h0, 1, 4'b0000, 32'h0);
    issue("st_f3_4", 1, 3'd4, 32'h100, 32'h0, 0, 32'h0, 32'h0, 1, 4'b0000, 32'h0);
    issue("sw_mis",  1, 3'd2, 32'h203, 32'h0, 0, 32'h0, 32'h0, 1, 4'b0000, 32'h0);
    issue("lw_d5",  0, 3'd2, 32'h108, 32'h0, 5, 32'hCAFEF00D, 32'hCAFEF00D, 0, 4'b0000, 32'h0);
    issue("lbu_d2", 0, 3'd4, 32'h10A, 32'h0, 2, 32'h11223344, 32'h00000022, 0, 4'b0000, 32'h0);

    // timeout on the short-timeout instance, then a late ack that must be ignored
    wait_ready();
    repeat (3) @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100; rv2 = 1'b1;
    e.rdata = 32'h0; e.err = 1'b1; e.at = cyc + 5;
    q2.push_back(e);
    @(posedge clk);
    #1 rv2 = 1'b0;
    mcnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (mem_req2) mcnt++;
      if (resp_valid2) break;
    end
    chk("to_memreq_cycles", 32'(mcnt), 32'd4);
    repeat (2) @(negedge clk);
    ack2 = 1'b1;
    @(negedge clk);
    ack2 = 1'b0;
    repeat (5) @(negedge clk);
    chk("to_late_ack_memreq", {31'd0, mem_req2}, 32'd0);
    chk("to_ready_after", {31'd0, req_ready2}, 32'd1);

    // reset in the middle of an access
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h104;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_memreq", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_outs", {28'd0, resp_valid, resp_err, mem_req, mem_we}, 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    chk("arst_wmask", {28'd0, mem_wmask}, 32'd0);
    chk("arst_rdata", resp_rdata, 32'd0);
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    issue("lw_post", 0, 3'd2, 32'h10C, 32'h0, 1, 32'h0BADF00D, 32'h0BADF00D, 0, 4'b0000, 32'h0);

    repeat (4) @(negedge clk);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
